ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports cpu_req, cpu_we, input, 1 each: CPU access request and write enable.
REQ-006 SHALL have ports cpu_addr (ADDR_WIDTH) and cpu_wdata (DATA_WIDTH), inputs: CPU address and write data.
REQ-007 SHALL have ports cpu_ack (1) and cpu_rdata (DATA_WIDTH), outputs: CPU completion pulse and read data.
REQ-008 SHALL have ports ldr_req, ldr_we (1 each), ldr_addr (ADDR_WIDTH) and ldr_wdata (DATA_WIDTH), inputs: program-loader request.
REQ-009 SHALL have ports ldr_ack (1) and ldr_rdata (DATA_WIDTH), outputs: loader completion pulse and read data.
REQ-010 SHALL have ports ram_we (1), ram_addr (ADDR_WIDTH) and ram_wdata (DATA_WIDTH), outputs: registered drive to a synchronous single-port RAM.
REQ-011 SHALL have port ram_rdata, input, DATA_WIDTH: RAM read data, valid one cycle after ram_addr is presented.
REQ-012 SHALL have port cpu_stall, output, 1: CPU must hold its state while high.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and ACK.
REQ-014 In IDLE, with no request: SHALL stay in IDLE.
REQ-015 In IDLE, with any request: SHALL record the winner, register its addr/we/wdata onto ram_*, and go to ACCESS.
REQ-016 ACCESS SHALL last exactly one cycle: ram_we high only here, and only if the winner's we=1; then go to ACK.
REQ-017 ACK SHALL last exactly one cycle: pulse the winner's ack high for one cycle, drive the winner's rdata = ram_rdata, then go to IDLE.
REQ-018 Latency: req sampled high at edge k -> ACCESS cycle k+1 -> ack high in cycle k+2; throughput is one access per 3 cycles.
REQ-019 Requester SHALL hold req, we, addr and wdata stable until it sees ack.
REQ-020 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-021 req inputs SHALL be ignored in ACCESS and ACK; addr/we/wdata are captured only on the IDLE->ACCESS edge.
REQ-022 Non-granted rdata outputs and ack outputs SHALL be 0.
REQ-023 ram_we SHALL be 0 outside ACCESS; ram_addr and ram_wdata SHALL hold their last value.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-025 Simultaneous cpu_req and ldr_req in IDLE: winner per REQ-031/REQ-032; the loser stays pending and is served next.
REQ-026 Address and data SHALL pass through unmodified, with no width conversion; a full-range address (all ones) is legal.

Reset
REQ-027 reset high at a clock edge SHALL force IDLE, regardless of current state.
REQ-028 After reset: cpu_ack=0, ldr_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata outputs=0, round-robin pointer = CPU.
REQ-029 Reset during ACCESS SHALL abort the access: ram_we low from the next cycle, no ack issued, and the requester must re-request.
REQ-030 Reset held for several cycles SHALL keep all outputs at reset values and SHALL NOT grant.

Configuration
REQ-031 Macro RAM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not served last; the pointer updates on every ACK.
REQ-032 Macro RAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, loader always beats CPU, and no pointer register exists.

Verification
REQ-033 Reset, then CPU write addr 0x0010 data 0x2A -> ram_we=1 with ram_addr=0x0010 in cycle k+1, cpu_ack in cycle k+2; CPU read of 0x0010 -> cpu_rdata=0x2A with cpu_ack.
REQ-034 Loader writes 0x00..0x0F to 0x0000..0x000F back-to-back -> 16 ldr_ack pulses, 48 cycles total, RAM contents match.
REQ-035 cpu_req and ldr_req both raised in the same cycle and held:
  - RAM_ARB_ROUND_ROBIN_EN: grant order CPU, LDR, CPU, LDR.
  - without the macro: LDR every time while ldr_req is high; cpu_stall stays 1.
REQ-036 reset asserted in the ACCESS cycle of a CPU write to 0x0020 -> no cpu_ack, ram_we=0 the following cycle, all outputs at reset values.
REQ-037 CPU read of 0xFFFF (preloaded 0x5A) -> cpu_rdata=0x5A with cpu_ack; ldr_rdata=0 and ldr_ack=0 throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous single-port RAM between a CPU and a program loader.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the loader has fixed priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  cpu_stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t state, state_nxt;
    logic win_ldr, pick_ldr, start;
    assign start = (state == IDLE) && (cpu_req || ldr_req);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    // prio_ldr set means the loader wins the next tie (the CPU was served last)
    logic prio_ldr;
    always_ff @(posedge clk) begin
        if (reset) prio_ldr <= 1'b0;
        else if (state == ACK) prio_ldr <= !win_ldr;
    end
    assign pick_ldr = ldr_req && (!cpu_req || prio_ldr);
`else
    assign pick_ldr = ldr_req;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win_ldr   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state  <= state_nxt;
            ram_we <= 1'b0;
            if (start) begin
                win_ldr   <= pick_ldr;
                ram_we    <= pick_ldr ? ldr_we    : cpu_we;
                ram_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
                ram_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        cpu_ack   = 1'b0;
        ldr_ack   = 1'b0;
        cpu_rdata = '0;
        ldr_rdata = '0;
        case (state)
            IDLE:    state_nxt = start ? ACCESS : IDLE;
            ACCESS:  state_nxt = ACK;
            ACK: begin
                state_nxt = IDLE;
                cpu_ack   = !win_ldr;
                ldr_ack   = win_ldr;
                cpu_rdata = win_ldr ? '0 : ram_rdata;
                ldr_rdata = win_ldr ? ram_rdata : '0;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign cpu_stall = cpu_req && !cpu_ack;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [15:0] cpu_addr = '0, ldr_addr = '0;
    logic [7:0]  cpu_wdata = '0, ldr_wdata = '0;
    logic        cpu_ack, ldr_ack, ram_we, cpu_stall;
    logic [7:0]  cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;
    logic [7:0]  mem [0:65535];
    logic [7:0]  sb [$];
    bit          gq [$];
    int          vectors = 0, errs = 0;

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access by either requester; checks latency, RAM drive and read data
    task automatic do_access(input bit ldr, input logic we, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] exp, input string tag);
        int  n = 0;
        bit  seen = 0;
        logic ack;
        @(negedge clk);
        if (!we) sb.push_back(exp);
        if (ldr) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            chk({tag, "_other_ack"}, ldr ? cpu_ack : ldr_ack, 1'b0);
            chk({tag, "_other_rdata"}, ldr ? cpu_rdata : ldr_rdata, 8'h00);
            if (n == 1) begin
                chk({tag, "_ram_we"}, ram_we, we);
                chk({tag, "_ram_addr"}, ram_addr, a);
                if (we) chk({tag, "_ram_wdata"}, ram_wdata, d);
                if (!ldr) chk({tag, "_stall"}, cpu_stall, 1'b1);
            end
            ack = ldr ? ldr_ack : cpu_ack;
            if (ack) begin
                seen = 1;
                chk({tag, "_latency"}, n, 2);
                chk({tag, "_ram_we_off"}, ram_we, 1'b0);
                if (!ldr) chk({tag, "_stall_off"}, cpu_stall, 1'b0);
                if (!we) chk({tag, "_rdata"}, ldr ? ldr_rdata : cpu_rdata, sb.pop_front());
                if (ldr) ldr_req = 0; else cpu_req = 0;
            end
        end
        chk({tag, "_ack_seen"}, seen, 1'b1);
        cpu_req = 0;
        ldr_req = 0;
    endtask

    initial begin
        int cyc, acks;
        bit g;
        // reset held with a pending request must not grant
        reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ram_we", ram_we, 1'b0);
            chk("rst_cpu_ack", cpu_ack, 1'b0);
            chk("rst_ram_addr", ram_addr, 16'h0000);
            chk("rst_ram_wdata", ram_wdata, 8'h00);
            chk("rst_ldr_ack", ldr_ack, 1'b0);
            chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        end
        reset = 0; cpu_req = 0;

        do_access(0, 1, 16'h0010, 8'h2A, 8'h00, "cpu_wr10");
        do_access(0, 0, 16'h0010, 8'h00, 8'h2A, "cpu_rd10");

        // loader burst: 16 back-to-back writes with req held high
        @(negedge clk);
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0000; ldr_wdata = 8'h00;
        cyc = 0; acks = 0;
        while (acks < 16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ldr_ack) begin
                acks++;
                if (acks < 16) begin ldr_addr = 16'(acks); ldr_wdata = 8'(acks); end
                else ldr_req = 0;
            end
        end
        ldr_req = 0;
        chk("ldr_burst_acks", acks, 16);
        chk("ldr_burst_cycles", cyc + 1, 48);
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk("ldr_burst_mem", mem[i], 8'(i));

        // simultaneous requests, both held
`ifdef RAM_ARB_ROUND_ROBIN_EN
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
`else
        gq.push_back(1); gq.push_back(1); gq.push_back(1); gq.push_back(0);
`endif
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0005;
        cyc = 0;
        while (gq.size() != 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
`ifndef RAM_ARB_ROUND_ROBIN_EN
            if (ldr_req) chk("tie_stall", cpu_stall, 1'b1);
`endif
            if (cpu_ack || ldr_ack) begin
                g = gq.pop_front();
                chk("tie_grant", {cpu_ack, ldr_ack}, g ? 2'b01 : 2'b10);
                chk("tie_rdata", g ? ldr_rdata : cpu_rdata, g ? 8'h05 : 8'h2A);
`ifndef RAM_ARB_ROUND_ROBIN_EN
                if (gq.size() == 1) ldr_req = 0;
`endif
            end
        end
        cpu_req = 0; ldr_req = 0;
        chk("tie_all_granted", gq.size(), 0);

        // reset in the ACCESS cycle aborts the write
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 8'h77;
        @(negedge clk);
        chk("abort_access_we", ram_we, 1'b1);
        reset = 1; cpu_req = 0;
        @(negedge clk);
        chk("abort_ram_we", ram_we, 1'b0);
        chk("abort_cpu_ack", cpu_ack, 1'b0);
        chk("abort_ram_addr", ram_addr, 16'h0000);
        chk("abort_ram_wdata", ram_wdata, 8'h00);
        chk("abort_ldr_ack", ldr_ack, 1'b0);
        chk("abort_cpu_rdata", cpu_rdata, 8'h00);
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ack", cpu_ack, 1'b0);
        end

        // full-range address
        do_access(1, 1, 16'hFFFF, 8'h5A, 8'h00, "ldr_wrffff");
        do_access(0, 0, 16'hFFFF, 8'h00, 8'h5A, "cpu_rdffff");
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
